z80_stack_seq: RTL

Stack sequencer for the Z80 core. It owns the architectural SP register and turns 16-bit PUSH/POP requests (PUSH IX/IY, PUSH rr, POP rr, CALL/RET return address) into two byte-wide memory cycles on a request/acknowledge memory port. It sits between instruction decode/execute and the shared memory bus. Its SP and byte-address behaviour matches the z80fi PUSH/POP instruction specs exactly.

---
 rtl/z80_stack_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/z80_stack_seq.sv
// Z80 stack sequencer: owns SP, splits 16-bit PUSH/POP into two byte memory cycles.
// Latency: request at edge 0, bytes in cycles 1-2, done/new sp in cycle 3 (zero-wait); +1 cycle per wait state.
// Backpressure: holds mem_req/addr/data stable until mem_ack; push/pop/ld_sp only sampled while idle (not latched).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   push_req/push_data           16-bit push request (captured on acceptance)
//   pop_req                      16-bit pop request
//   ld_sp/sp_load                direct SP load, idle only, no memory cycle
//   sp, busy, done, pop_data     architectural SP, in-progress flag, completion pulse, last popped word
//   mem_req/mem_wr/mem_addr/
//   mem_wdata/mem_ack/mem_rdata  byte-wide request/acknowledge memory port
module z80_stack_seq #(
    parameter logic [15:0] SP_RESET = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_req,
    input  logic [15:0] push_data,
    input  logic        pop_req,
    input  logic        ld_sp,
    input  logic [15:0] sp_load,
    output logic [15:0] sp,
    output logic        busy,
    output logic        done,
    output logic [15:0] pop_data,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PUSH_HI = 3'd1;
    localparam logic [2:0] S_PUSH_LO = 3'd2;
    localparam logic [2:0] S_POP_LO  = 3'd3;
    localparam logic [2:0] S_POP_HI  = 3'd4;

    logic [2:0] state;
    // Only the low push byte needs holding: the high byte goes straight to
    // mem_wdata on acceptance.
    logic [7:0] push_lo;
    logic [7:0] pop_lo;

    // mem_req is high in every non-idle state, so mem_ack alone qualifies
    // a completed memory cycle there; in idle mem_ack is never looked at.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            sp        <= SP_RESET;
            busy      <= 1'b0;
            done      <= 1'b0;
            pop_data  <= 16'h0000;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            push_lo   <= 8'h00;
            pop_lo    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld_sp) begin
                        sp <= sp_load;
                    end else if (push_req) begin
                        push_lo   <= push_data[7:0];
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b1;
                        mem_addr  <= sp - 16'd1;
                        mem_wdata <= push_data[15:8];
                        busy      <= 1'b1;
                        state     <= S_PUSH_HI;
                    end else if (pop_req) begin
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= sp;
                        busy      <= 1'b1;
                        state     <= S_POP_LO;
                    end
                end
                S_PUSH_HI: begin
                    if (mem_ack) begin
                        mem_addr  <= sp - 16'd2;
                        mem_wdata <= push_lo;
                        state     <= S_PUSH_LO;
                    end
                end
                S_PUSH_LO: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        sp      <= sp - 16'd2;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_POP_LO: begin
                    if (mem_ack) begin
                        pop_lo   <= mem_rdata;
                        mem_addr <= sp + 16'd1;
                        state    <= S_POP_HI;
                    end
                end
                S_POP_HI: begin
                    if (mem_ack) begin
                        pop_data <= {mem_rdata, pop_lo};
                        mem_req  <= 1'b0;
                        sp       <= sp + 16'd2;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
